// File: rtl/tach_decoder_pkg.sv
// rtl/tach_decoder_pkg.sv - shared constants, FSM encoding and helpers for the tach decoder
package tach_decoder_pkg;

  localparam int WF_CLK_HZ = 16_000_000;

  // 100 ms without an A edge at the nominal system clock.
  localparam int DEF_STALL_CYCLES = WF_CLK_HZ / 10;
  localparam int DEF_FILT_LEN     = 4;

  localparam logic [1:0] TACH_IDLE  = 2'd0;
  localparam logic [1:0] TACH_RUN   = 2'd1;
  localparam logic [1:0] TACH_STALL = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tach_decoder_if.sv
// rtl/tach_decoder_if.sv - encoder inputs and decoded outputs of one wheel tach channel
interface tach_decoder_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20
);

  logic             enc_a;
  logic             enc_b;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             edge_pulse;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             stalled;

  modport master (
    output enc_a, enc_b, clr,
    input  count, dir, edge_pulse, period, period_valid, stalled
  );

  modport slave (
    input  enc_a, enc_b, clr,
    output count, dir, edge_pulse, period, period_valid, stalled
  );

endinterface

// File: rtl/tach_sync_filter.sv
// rtl/tach_sync_filter.sv - two-flop synchronizer with optional glitch filter (TACH_GLITCH_FILTER_EN)
// With the filter, dout follows the synchronized level only after it has held FILT_LEN cycles.
module tach_sync_filter
  import tach_decoder_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

`ifdef TACH_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  generate
    if (FILT_EN && FILT_LEN >= 1) begin : g_filt
      localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
      localparam logic [CW-1:0] HOLD_LAST = CW'(FILT_LEN - 1);

      logic [CW-1:0] hold;
      logic          level;

      // Any return to the current level restarts the qualification window.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold  <= '0;
          level <= 1'b0;
        end else if (sync == level) begin
          hold <= '0;
        end else if (hold == HOLD_LAST) begin
          hold  <= '0;
          level <= sync;
        end else begin
          hold <= hold + 1'b1;
        end
      end

      assign dout = level;
    end else begin : g_pass
      assign dout = sync;
    end
  endgenerate

endmodule

// File: rtl/tach_decoder.sv
// rtl/tach_decoder.sv - wheel tach decoder: signed edge count, direction, A-edge period, stall flag
// Build option: TACH_GLITCH_FILTER_EN enables the input glitch filter in tach_sync_filter.
module tach_decoder
  import tach_decoder_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int PER_W        = 20,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int FILT_LEN     = DEF_FILT_LEN
) (
  input logic           WF_CLK,
  input logic           WF_RST_N,
  tach_decoder_if.slave bus
);

  // Timer is widened so the stall threshold stays reachable even when it exceeds the period range.
  localparam int TMR_W = max_int(PER_W, $clog2(STALL_CYCLES + 1));
  localparam logic [TMR_W-1:0] TMR_MAX    = '1;
  localparam logic [TMR_W-1:0] PER_MAX    = TMR_W'({PER_W{1'b1}});
  localparam logic [TMR_W-1:0] STALL_LAST = TMR_W'(STALL_CYCLES - 1);

  logic             a_s;
  logic             b_s;
  logic             prev_a;
  logic             a_rise;
  logic [1:0]       state;
  logic [TMR_W-1:0] timer;
  logic [PER_W-1:0] period_next;
  logic [CNT_W-1:0] count_q;
  logic             dir_q;
  logic             edge_q;
  logic [PER_W-1:0] period_q;
  logic             period_valid_q;

  tach_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
    .clk   (WF_CLK),
    .rst_n (WF_RST_N),
    .din   (bus.enc_a),
    .dout  (a_s)
  );

  tach_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
    .clk   (WF_CLK),
    .rst_n (WF_RST_N),
    .din   (bus.enc_b),
    .dout  (b_s)
  );

  always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
    if (!WF_RST_N) begin
      prev_a <= 1'b0;
    end else begin
      prev_a <= a_s;
    end
  end

  assign a_rise = a_s & ~prev_a;

  // Period is the timer value plus the current cycle, clamped to the output range.
  assign period_next = (timer >= PER_MAX) ? {PER_W{1'b1}} : (timer[PER_W-1:0] + 1'b1);

  always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
    if (!WF_RST_N) begin
      timer <= '0;
    end else if (a_rise) begin
      timer <= '0;
    end else if (timer != TMR_MAX) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
    if (!WF_RST_N) begin
      count_q <= '0;
      dir_q   <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      edge_q <= a_rise;
      if (a_rise) begin
        dir_q <= b_s;
      end
      if (bus.clr) begin
        count_q <= '0;
      end else if (a_rise) begin
        count_q <= b_s ? (count_q - 1'b1) : (count_q + 1'b1);
      end
    end
  end

  always_ff @(posedge WF_CLK or negedge WF_RST_N) begin
    if (!WF_RST_N) begin
      state          <= TACH_IDLE;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      case (state)
        TACH_IDLE, TACH_STALL: begin
          // First edge after idle/stall only restarts timing; no period is known yet.
          if (a_rise) begin
            state <= TACH_RUN;
          end
        end
        TACH_RUN: begin
          if (a_rise) begin
            period_q       <= period_next;
            period_valid_q <= 1'b1;
          end else if (timer == STALL_LAST) begin
            state    <= TACH_STALL;
            period_q <= '0;
          end
        end
        default: begin
          state <= TACH_IDLE;
        end
      endcase
    end
  end

  assign bus.count        = count_q;
  assign bus.dir          = dir_q;
  assign bus.edge_pulse   = edge_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.stalled      = (state == TACH_STALL);

endmodule

// File: doc/tach_decoder.md
# tach_decoder

Wheel-tachometer decoder for the RSLK chassis encoders: reads one wheel's A/B tach outputs, keeps a signed edge count, reports direction, measures the period between A edges for speed, and flags a stalled wheel. It sits beside the motor PWM driver in the top level, one instance per wheel, and feeds the drive state machines closed-loop distance and speed data.

## Interface
- CNT_W, 16, width of position count (two's complement)
- PER_W, 20, width of period timer/output
- STALL_CYCLES, 1600000, cycles without an A edge before stall (100 ms at 16 MHz)
- FILT_LEN, 4, glitch-filter hold length in cycles (used only with filter macro)

- WF_CLK  in  1  system clock; all logic on rising edge
- WF_RST_N  in  1  asynchronous, active-low reset
- enc_a  in  1  raw tach A (asynchronous to WF_CLK)
- enc_b  in  1  raw tach B (asynchronous to WF_CLK)
- clr  in  1  synchronous clear of count
- count  out  CNT_W  signed edge count
- dir  out  1  0 = forward, 1 = reverse (from last edge)
- edge_pulse  out  1  one-cycle pulse per decoded A rising edge
- period  out  PER_W  cycles between last two A rising edges
- period_valid  out  1  one-cycle pulse when period updates
- stalled  out  1  no A edge for STALL_CYCLES

## Operation
- enc_a, enc_b pass through two-flop synchronizers; A rise = sync_a & ~prev_a.
- On A rise: B sync = 0 -> count+1, dir=0; B sync = 1 -> count-1, dir=1. count wraps modulo 2^CNT_W.
- clr: count <= 0; clr with a coincident edge -> clr wins, count=0, dir still updates.
- Period timer: increments every cycle, saturates at 2^PER_W-1; on A rise, timer <= 0. Edges N cycles apart -> period = N (timer+1, saturating).
- FSM states: IDLE (post-reset), RUN, STALL.
  - IDLE: A rise -> RUN, timer cleared, no period_valid.
  - RUN: A rise -> period <= timer+1, period_valid=1, stay. timer == STALL_CYCLES-1 with no edge -> STALL, period <= 0.
  - STALL: stalled=1; A rise -> RUN, timer cleared, no period_valid.
- stalled = 1 only in STALL.
- Reset values: count=0, dir=0, edge_pulse=0, period=0, period_valid=0, stalled=0, state IDLE, timer=0, sync flops 0.
- Reset mid-operation clears everything immediately; no edge is counted from the pre-reset prev_a.

## Timing
- A rising edge first sampled at WF_CLK edge k -> count, dir, edge_pulse, period, period_valid registered at edge k+2 (3 clocks including sampling); +FILT_LEN with filter.
- edge_pulse and period_valid assert the same cycle, width exactly 1.
- Minimum resolvable A high/low time: 2 cycles (FILT_LEN+1 with filter).
- Stall asserts exactly STALL_CYCLES cycles after the last edge's timer clear.

## Configuration
- TACH_GLITCH_FILTER_EN defined: each synchronized input feeds a filter whose output changes only after the new level holds for FILT_LEN consecutive cycles; shorter pulses are discarded; latency +FILT_LEN.
- Undefined: synchronized inputs feed edge detection directly; FILT_LEN is ignored.

## Structure
- Shared package: FSM state encoding (TACH_IDLE, TACH_RUN, TACH_STALL), default STALL_CYCLES and WF_CLK frequency constant.
- One sub-module, tach_sync_filter: 2-flop synchronizer plus optional glitch filter, instantiated for A and B.

## Test plan
- Reset held, toggle inputs -> all outputs 0; release -> state IDLE, stalled=0.
- enc_b=0, 5 A pulses every 100 cycles -> count=5, dir=0, 5 edge_pulses, 4 period_valid with period=100.
- enc_b=1, 3 A pulses -> count=-3 (0xFFFD), dir=1; CNT_W=4 with 16 forward edges -> count wraps to 0.
- STALL_CYCLES=1000, stop after edge -> stalled=1 exactly 1000 cycles later, period=0; next edge -> stalled=0, no period_valid; following edge at 200 cycles -> period=200.
- clr coincident with an A edge -> count=0; WF_RST_N low mid-RUN -> outputs zero asynchronously, IDLE.
- 2-cycle glitch on enc_a: with TACH_GLITCH_FILTER_EN (FILT_LEN=4) -> no count change; without -> count+1.
